wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL be clocked by clk and reset by reset, synchronous, active-high.
REQ-002 Parameters SHALL be, as name, default, meaning:
  XLEN, 64, data width.
  NREGS, 32, architectural registers.
  LDQ_DEPTH, 2, load-result queue entries.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  clock.
  reset  in  1  sync active-high reset.
  issue_valid  in  1  an instruction writing issue_rd issued this cycle.
  issue_rd  in  5  destination of the issued instruction.
  alu_valid  in  1  ALU result offered.
  alu_ready  out  1  ALU result accepted when both are high.
  alu_rd  in  5  ALU destination.
  alu_data  in  XLEN  ALU result.
  ld_valid  in  1  load result offered.
  ld_ready  out  1  load result accepted when both are high.
  ld_rd  in  5  load destination.
  ld_data  in  XLEN  load result.
  rf_we  out  1  register-file write enable.
  rf_waddr  out  5  register-file write address.
  rf_wdata  out  XLEN  register-file write data.
  rs1, rs2  in  5 each  decode-stage source indices.
  rs1_busy, rs2_busy  out  1 each  source has an outstanding write.
  ldq_count  out  2  load-queue occupancy.

Function
REQ-004 ld_ready SHALL be (ldq_count < LDQ_DEPTH) and alu_ready SHALL be (ldq_count == 0), each a function of registered state only, with no valid-to-ready path.
REQ-005 An accepted load SHALL enqueue into the FIFO at the clock edge; the queue SHALL be FIFO-ordered with wrap-around pointers.
REQ-006 At most one write SHALL be selected per cycle: the queue head when ldq_count > 0, otherwise an accepted ALU result, otherwise none.
REQ-007 Outputs rf_we, rf_waddr and rf_wdata SHALL be registered: a selection made in cycle N appears in cycle N+1, for exactly one cycle.
REQ-008 ALU latency SHALL be 1 cycle from acceptance to rf_we; a load accepted into an empty queue SHALL reach rf_we 2 cycles after acceptance.
REQ-009 A selected result with rd == 0 SHALL complete its handshake and dequeue, but SHALL leave rf_we low.
REQ-010 When the queue is full, ld_ready SHALL be low even if a dequeue happens in the same cycle.
REQ-011 Simultaneous load accept and ALU accept (empty queue) SHALL write the ALU result and enqueue the load.
REQ-012 The scoreboard SHALL hold NREGS pending bits:
  - issue_valid with issue_rd != 0 sets the bit for issue_rd;
  - a selected result with rd != 0 clears the bit for rd at the same edge that registers rf_we.
REQ-013 If set and clear target the same register in the same cycle, set SHALL win.
REQ-014 rsX_busy SHALL equal pending[rsX] combinationally; rsX_busy for x0 SHALL always be 0.
REQ-015 While rf_we is high, rsX_busy for rf_waddr SHALL already be 0, so the register file's write-through supplies the value.
REQ-016 Holding a result at valid without ready SHALL not alter its rd or data; the block SHALL not drop or duplicate any accepted result.

Reset
REQ-017 While reset is high at a clock edge, the block SHALL:
  - empty the queue (ldq_count = 0);
  - clear all pending bits;
  - set rf_we = 0, rf_waddr = 0, rf_wdata = 0.
REQ-018 Reset mid-operation SHALL discard queued loads without writing them; handshakes are ignored during reset.
REQ-019 In the cycle after reset deasserts, ld_ready SHALL be 1 and alu_ready SHALL be 1.

Structure
REQ-020 A shared package wb_pkg SHALL hold XLEN, NREGS, REG_AW = 5, LDQ_DEPTH and the struct wb_req_t {rd, data}.
REQ-021 The load queue SHALL be a sub-module wb_ldq (parameterised FIFO of wb_req_t with count output); the scoreboard and arbitration SHALL remain in wb_arbiter.

Verification
REQ-022 ALU result rd = 5, data = 0xAB accepted in cycle N -> rf_we = 1, rf_waddr = 5, rf_wdata = 0xAB in cycle N+1 only.
REQ-023 Loads rd = 4 then rd = 6 back-to-back with a continuous ALU offer -> alu_ready low while queue non-empty; writes occur in order 4, 6, then the ALU write; ld_ready drops when ldq_count = 2.
REQ-024 issue_valid rd = 7 then ALU result rd = 7 -> rs1 = 7 shows busy = 1 until the edge rf_we rises; busy = 0 during the rf_we cycle.
REQ-025 Same-cycle issue rd = 3 and write-select rd = 3 -> pending[3] stays 1; issue rd = 0 -> rs1_busy for 0 stays 0; ALU write to rd = 0 -> no rf_we.
REQ-026 Reset asserted with 2 queued loads -> no rf_we afterwards, ldq_count = 0, all busy flags 0, both readies 1 in the following cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and the write-back request record used by the arbiter and its load queue.
package wb_pkg;

   localparam int XLEN      = 64;
   localparam int NREGS     = 32;
   localparam int REG_AW    = 5;
   localparam int LDQ_DEPTH = 2;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_ldq.sv
// Load-result FIFO: wrap-around pointers, occupancy count, head always visible.
module wb_ldq
   import wb_pkg::*;
#(
   parameter int DEPTH = LDQ_DEPTH,
   parameter int CW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  wb_req_t       push_data,
   input  logic          pop,
   output wb_req_t       head,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign head = mem[rd_ptr];

   // The caller never pushes when full nor pops when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results onto one register-file write port
// and tracks outstanding destinations in a pending-bit scoreboard.
module wb_arbiter #(
   parameter int XLEN      = wb_pkg::XLEN,
   parameter int NREGS     = wb_pkg::NREGS,
   parameter int LDQ_DEPTH = wb_pkg::LDQ_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic [1:0]      ldq_count
);

   import wb_pkg::*;

   wb_req_t          ld_req;
   wb_req_t          ldq_head;
   wb_req_t          sel;
   logic             sel_valid;
   logic             ldq_pop;
   logic             ld_acc;
   logic             alu_acc;
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pend_set;
   logic [NREGS-1:0] pend_clr;

   // Readies depend only on queue occupancy, never on the offered valids.
   assign ld_ready  = (32'(ldq_count) < LDQ_DEPTH);
   assign alu_ready = (ldq_count == '0);
   assign ld_acc    = ld_valid && ld_ready;
   assign alu_acc   = alu_valid && alu_ready;

   assign ld_req.rd   = ld_rd;
   assign ld_req.data = ld_data;

   wb_ldq #(
      .DEPTH (LDQ_DEPTH),
      .CW    (2)
   ) u_ldq (
      .clk       (clk),
      .reset     (reset),
      .push      (ld_acc),
      .push_data (ld_req),
      .pop       (ldq_pop),
      .head      (ldq_head),
      .count     (ldq_count)
   );

   // Queued loads drain first so older results are never overtaken.
   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      ldq_pop   = 1'b0;
      if (ldq_count != '0) begin
         sel_valid = 1'b1;
         sel       = ldq_head;
         ldq_pop   = 1'b1;
      end else if (alu_acc) begin
         sel_valid = 1'b1;
         sel.rd    = alu_rd;
         sel.data  = alu_data;
      end
   end

   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (sel_valid && sel.rd != '0)         pend_clr[sel.rd]   = 1'b1;
      if (issue_valid && issue_rd != '0)     pend_set[issue_rd] = 1'b1;
   end

   assign rs1_busy = (rs1 != '0) && pending[rs1];
   assign rs2_busy = (rs2 != '0) && pending[rs2];

   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         pending <= (pending & ~pend_clr) | pend_set;
         rf_we   <= sel_valid && (sel.rd != '0);
         if (sel_valid) begin
            rf_waddr <= sel.rd;
            rf_wdata <= sel.data;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset sequence, then random traffic vs a queue model.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [63:0] ld_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [4:0]  rs1, rs2;
   logic        rs1_busy, rs2_busy;
   logic [1:0]  ldq_count;

   wb_arbiter dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .ldq_count(ldq_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } res_t;

   // Reference model: pending queue of load results, pending-register set, expected write port.
   res_t        q[$];
   bit [31:0]   pend;
   bit          exp_we;
   logic [4:0]  exp_waddr;
   logic [63:0] exp_wdata;
   bit          last_ld_acc, last_alu_acc;

   typedef struct packed {
      logic        iv;  logic [4:0] ird;
      logic        av;  logic [4:0] ard; logic [63:0] ad;
      logic        lv;  logic [4:0] lrd; logic [63:0] ld;
      logic [4:0]  r1;  logic [4:0] r2;
      logic        e_ldr; logic e_alur; logic [1:0] e_cnt;
      logic        e_we; logic [4:0] e_wa; logic [63:0] e_wd;
      logic        e_b1; logic e_b2;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pend      = '0;
      exp_we    = 1'b0;
      exp_waddr = '0;
      exp_wdata = '0;
   endtask

   task automatic model_step();
      bit   ld_acc, alu_acc, have;
      res_t s;
      have = 1'b0;
      s    = '0;
      if (reset) begin
         model_reset();
         last_ld_acc  = 1'b1;
         last_alu_acc = 1'b1;
      end else begin
         ld_acc  = ld_valid && (q.size() < 2);
         alu_acc = alu_valid && (q.size() == 0);
         if (q.size() > 0) begin
            s    = q.pop_front();
            have = 1'b1;
         end else if (alu_acc) begin
            s    = '{rd: alu_rd, data: alu_data};
            have = 1'b1;
         end
         if (ld_acc) q.push_back('{rd: ld_rd, data: ld_data});
         if (have && s.rd != 0) pend[s.rd] = 1'b0;
         if (issue_valid && issue_rd != 0) pend[issue_rd] = 1'b1;
         exp_we = have && (s.rd != 0);
         if (exp_we) begin
            exp_waddr = s.rd;
            exp_wdata = s.data;
         end
         last_ld_acc  = ld_acc;
         last_alu_acc = alu_acc;
      end
   endtask

   // One clock: compare at the falling edge, advance the model, then move past the rising edge.
   task automatic cycle(input string tag, input int vi);
      vec_t v;
      @(negedge clk);
      if (vi >= 0) begin
         v = vecs[vi];
         chk($sformatf("%s[%0d] ld_ready", tag, vi), 64'(ld_ready), 64'(v.e_ldr));
         chk($sformatf("%s[%0d] alu_ready", tag, vi), 64'(alu_ready), 64'(v.e_alur));
         chk($sformatf("%s[%0d] ldq_count", tag, vi), 64'(ldq_count), 64'(v.e_cnt));
         chk($sformatf("%s[%0d] rf_we", tag, vi), 64'(rf_we), 64'(v.e_we));
         if (v.e_we) begin
            chk($sformatf("%s[%0d] rf_waddr", tag, vi), 64'(rf_waddr), 64'(v.e_wa));
            chk($sformatf("%s[%0d] rf_wdata", tag, vi), rf_wdata, v.e_wd);
         end
         chk($sformatf("%s[%0d] rs1_busy", tag, vi), 64'(rs1_busy), 64'(v.e_b1));
         chk($sformatf("%s[%0d] rs2_busy", tag, vi), 64'(rs2_busy), 64'(v.e_b2));
      end
      chk({tag, " model ld_ready"}, 64'(ld_ready), 64'(q.size() < 2));
      chk({tag, " model alu_ready"}, 64'(alu_ready), 64'(q.size() == 0));
      chk({tag, " model ldq_count"}, 64'(ldq_count), 64'(q.size()));
      chk({tag, " model rs1_busy"}, 64'(rs1_busy), 64'(rs1 != 0 && pend[rs1]));
      chk({tag, " model rs2_busy"}, 64'(rs2_busy), 64'(rs2 != 0 && pend[rs2]));
      chk({tag, " model rf_we"}, 64'(rf_we), 64'(exp_we));
      if (exp_we) begin
         chk({tag, " model rf_waddr"}, 64'(rf_waddr), 64'(exp_waddr));
         chk({tag, " model rf_wdata"}, rf_wdata, exp_wdata);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_rd = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      rs1 = 0; rs2 = 0;
   endtask

   initial begin
      //          iv ird av ard ad      lv lrd ld      r1 r2 ldr alur cnt we wa wd      b1 b2
      vecs.push_back('{0, 0, 1, 5, 'hAB, 0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 1, 5, 'hAB, 0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    1, 4, 'h44, 0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 1, 9, 'h99, 1, 6, 'h66, 0, 0, 1, 0, 1, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 1, 9, 'h99, 0, 0, 0,    0, 0, 1, 0, 1, 1, 4, 'h44, 0, 0});
      vecs.push_back('{0, 0, 1, 9, 'h99, 0, 0, 0,    0, 0, 1, 1, 0, 1, 6, 'h66, 0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 1, 9, 'h99, 0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{1, 7, 0, 0, 0,    0, 0, 0,    7, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 1, 7, 'h77, 0, 0, 0,    7, 7, 1, 1, 0, 0, 0, 0,    1, 1});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    7, 0, 1, 1, 0, 1, 7, 'h77, 0, 0});
      vecs.push_back('{1, 3, 0, 0, 0,    0, 0, 0,    3, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{1, 3, 1, 3, 'h33, 0, 0, 0,    3, 0, 1, 1, 0, 0, 0, 0,    1, 0});
      vecs.push_back('{0, 0, 1, 3, 'h34, 0, 0, 0,    3, 0, 1, 1, 0, 1, 3, 'h33, 1, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    3, 0, 1, 1, 0, 1, 3, 'h34, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0,    0, 0, 0,    0, 3, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 1, 0, 'hEE, 0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    1, 0, 'h1,  0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 0, 1, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});
      vecs.push_back('{0, 0, 0, 0, 0,    0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0,    0, 0});

      idle_inputs();
      reset = 1;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      reset = 0;
      chk("reset rf_we", 64'(rf_we), 64'd0);
      chk("reset rf_waddr", 64'(rf_waddr), 64'd0);
      chk("reset rf_wdata", rf_wdata, 64'd0);
      chk("reset ldq_count", 64'(ldq_count), 64'd0);
      chk("reset ld_ready", 64'(ld_ready), 64'd1);
      chk("reset alu_ready", 64'(alu_ready), 64'd1);
      cycle("idle", -1);

      for (int i = 0; i < vecs.size(); i++) begin
         issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
         alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
         ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_data = vecs[i].ld;
         rs1 = vecs[i].r1; rs2 = vecs[i].r2;
         cycle("vec", i);
      end

      // Reset while a load is queued and a register is pending.
      idle_inputs();
      ld_valid = 1; ld_rd = 12; ld_data = 'hC0FFEE;
      issue_valid = 1; issue_rd = 12;
      cycle("rstseq load", -1);
      ld_rd = 13; issue_rd = 13;
      reset = 1;
      cycle("rstseq assert", -1);
      idle_inputs();
      reset = 0;
      rs1 = 12; rs2 = 13;
      @(negedge clk);
      chk("rstseq ldq_count", 64'(ldq_count), 64'd0);
      chk("rstseq ld_ready", 64'(ld_ready), 64'd1);
      chk("rstseq alu_ready", 64'(alu_ready), 64'd1);
      chk("rstseq rs1_busy", 64'(rs1_busy), 64'd0);
      chk("rstseq rs2_busy", 64'(rs2_busy), 64'd0);
      chk("rstseq rf_we", 64'(rf_we), 64'd0);
      @(posedge clk);
      #1;
      repeat (3) cycle("rstseq after", -1);

      // Random traffic; a source keeps its payload stable until accepted.
      idle_inputs();
      last_ld_acc = 1; last_alu_acc = 1;
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 249) == 0);
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_rd = 5'($urandom_range(0, 7));
         if (!ld_valid || last_ld_acc) begin
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_rd    = 5'($urandom_range(0, 7));
            ld_data  = {$urandom, $urandom};
         end
         if (!alu_valid || last_alu_acc) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = {$urandom, $urandom};
         end
         rs1 = ($urandom_range(0, 1) == 1) ? rf_waddr : 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         cycle("rand", -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
